// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, branch flush, MDU hold and memory-wait freeze.
// Latency: enables/flushes/mdu_start are combinational; state and counters update on the clock edge.
// Backpressure: a memory stall (mem_req & ~dmem_ready) freezes every pipeline register, overriding all else.
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_is_mdu,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mdu_start,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_BUSY = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   mem_stall;
  logic   load_use;
  logic   branch_flush;

  assign mem_stall = mem_req && !dmem_ready;

  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  assign state = state_q;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_start    = 1'b0;
    branch_flush = 1'b0;
    state_d      = state_q;

    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = RUN;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = (state_q == MDU_BUSY) ? MDU_BUSY : MEM_WAIT;
    end else if (state_q == MDU_BUSY) begin
      if (mdu_done) begin
        state_d = RUN;
      end else begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        ex_mem_flush = 1'b1;
      end
    end else begin
      // A released MEM_WAIT (and the unused encoding) behaves exactly like RUN.
      state_d = RUN;
      if (ex_is_mdu) begin
        mdu_start    = 1'b1;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        ex_mem_flush = 1'b1;
        state_d      = MDU_BUSY;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q <= state_d;
      if (!pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed checks of hazard_control_unit (CNT_W=4) against hand-computed control vectors.
// Control vector order: pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex/ex_mem flushes, mdu_start.
module tb_hazard_control_unit;

  localparam int CNT_W = 4;

  localparam logic [8:0] ZERO   = 9'b00000_000_0;
  localparam logic [8:0] IDLE   = 9'b11111_000_0;
  localparam logic [8:0] LU     = 9'b00111_010_0;
  localparam logic [8:0] BR     = 9'b11111_110_0;
  localparam logic [8:0] MDU_S  = 9'b00001_001_1;
  localparam logic [8:0] MDU_B  = 9'b00001_001_0;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_is_mdu;
  logic             mdu_done;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mdu_start;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd_addr      (ex_rd_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_is_mdu       (ex_is_mdu),
    .mdu_done        (mdu_done),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mdu_start       (mdu_start),
    .state           (state),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mdu_start};
  endfunction

  task automatic idle_inputs();
    id_rs1_addr     = 5'd0;
    id_rs2_addr     = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    ex_rd_addr      = 5'd0;
    ex_mem_read     = 1'b0;
    ex_branch_taken = 1'b0;
    ex_is_mdu       = 1'b0;
    mdu_done        = 1'b0;
    mem_req         = 1'b0;
    dmem_ready      = 1'b1;
  endtask

  // Let combinational outputs settle mid-cycle, then advance one clock and step off the edge.
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use_rs2();
    ex_mem_read = 1'b1;
    ex_rd_addr  = 5'd5;
    id_rs2_addr = 5'd5;
    id_uses_rs2 = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctl", 32'(ctl()), 32'(ZERO));
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    rst = 1'b0;
    settle();
    chk("idle_ctl", 32'(ctl()), 32'(IDLE));
    tick();

    // Load-use on rs2: one stall cycle.
    set_load_use_rs2();
    settle();
    chk("lu_ctl", 32'(ctl()), 32'(LU));
    tick();
    idle_inputs();
    settle();
    chk("lu_release", 32'(ctl()), 32'(IDLE));
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    chk("lu_state", 32'(state), 32'd0);

    // x0 destination and unused-operand matches never stall.
    ex_mem_read = 1'b1;
    id_rs1_addr = 5'd0;
    id_uses_rs1 = 1'b1;
    settle();
    chk("lu_x0", 32'(ctl()), 32'(IDLE));
    ex_rd_addr  = 5'd7;
    id_rs1_addr = 5'd7;
    id_uses_rs1 = 1'b0;
    settle();
    chk("lu_unused_rs1", 32'(ctl()), 32'(IDLE));
    id_uses_rs1 = 1'b1;
    settle();
    chk("lu_rs1", 32'(ctl()), 32'(LU));
    tick();
    idle_inputs();
    settle();
    chk("lu_rs1_cnt", 32'(stall_cycles), 32'd2);

    // Branch together with load-use: branch wins.
    set_load_use_rs2();
    ex_branch_taken = 1'b1;
    settle();
    chk("br_lu_ctl", 32'(ctl()), 32'(BR));
    tick();
    idle_inputs();
    settle();
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd2);
    chk("br_state", 32'(state), 32'd0);

    // MDU launch: start cycle, three busy cycles, then the done cycle.
    ex_is_mdu = 1'b1;
    settle();
    chk("mdu_start_ctl", 32'(ctl()), 32'(MDU_S));
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mdu_busy_ctl", 32'(ctl()), 32'(MDU_B));
      chk("mdu_busy_state", 32'(state), 32'd1);
      tick();
    end
    mdu_done = 1'b1;
    settle();
    chk("mdu_done_ctl", 32'(ctl()), 32'(IDLE));
    chk("mdu_done_state", 32'(state), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("mdu_exit_state", 32'(state), 32'd0);
    chk("mdu_stall_cnt", 32'(stall_cycles), 32'd6);
    chk("mdu_idle_ctl", 32'(ctl()), 32'(IDLE));

    // Memory wait for two cycles; release cycle evaluated as RUN (branch applies).
    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    settle();
    chk("mw_ctl0", 32'(ctl()), 32'(ZERO));
    tick();
    settle();
    chk("mw_ctl1", 32'(ctl()), 32'(ZERO));
    chk("mw_state1", 32'(state), 32'd2);
    tick();
    chk("mw_state2", 32'(state), 32'd2);
    dmem_ready      = 1'b1;
    ex_branch_taken = 1'b1;
    settle();
    chk("mw_release_ctl", 32'(ctl()), 32'(BR));
    tick();
    idle_inputs();
    settle();
    chk("mw_exit_state", 32'(state), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cycles), 32'd8);
    chk("mw_flush_cnt", 32'(flush_count), 32'd2);

    // Memory stall while MDU_BUSY with mdu_done already high.
    ex_is_mdu = 1'b1;
    settle();
    chk("mm_start", 32'(ctl()), 32'(MDU_S));
    tick();
    mdu_done   = 1'b1;
    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("mm_stall_ctl", 32'(ctl()), 32'(ZERO));
      chk("mm_stall_state", 32'(state), 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    settle();
    chk("mm_release_ctl", 32'(ctl()), 32'(IDLE));
    chk("mm_release_state", 32'(state), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("mm_exit_state", 32'(state), 32'd0);
    chk("mm_stall_cnt", 32'(stall_cycles), 32'd11);

    // Reset while MDU_BUSY; a held mdu_done afterwards is ignored.
    ex_is_mdu = 1'b1;
    tick();
    chk("rb_busy_state", 32'(state), 32'd1);
    ex_is_mdu = 1'b0;
    mdu_done  = 1'b1;
    rst       = 1'b1;
    settle();
    chk("rb_rst_ctl", 32'(ctl()), 32'(ZERO));
    tick();
    chk("rb_state", 32'(state), 32'd0);
    chk("rb_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("rb_flush_cnt", 32'(flush_count), 32'd0);
    rst = 1'b0;
    settle();
    chk("rb_after_ctl", 32'(ctl()), 32'(IDLE));
    tick();
    chk("rb_after_state", 32'(state), 32'd0);
    idle_inputs();

    // Counter saturation at 4 bits.
    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(stall_cycles), 32'd15);
    chk("sat_state", 32'(state), 32'd2);
    idle_inputs();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_flush", 32'(flush_count), 32'd15);
    chk("sat_stall_hold", 32'(stall_cycles), 32'd15);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads rs1 / rs2.
REQ-007 ex_rd_addr  in  5; ex_mem_read  in  1  the EX instruction is a load.
REQ-008 ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-009 ex_is_mdu  in  1  the EX instruction is a multiply or divide.
REQ-010 mdu_done  in  1  MDU result valid; MDU holds it high until this block leaves MDU_BUSY.
REQ-011 mem_req  in  1  MEM stage is accessing data memory; dmem_ready  in  1  data memory accepts or returns this cycle.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register advance enables (1 = load).
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a NOP bubble into that register.
REQ-014 mdu_start  out  1  one-cycle MDU launch pulse.
REQ-015 state  out  2  RUN=00, MDU_BUSY=01, MEM_WAIT=10; 11 is unused.
REQ-016 stall_cycles, flush_count  out  CNT_W each  performance counters.

Function
REQ-017 Outputs other than the counters and state are combinational from state and inputs; default is all enables 1, all flushes 0, mdu_start 0.
REQ-018 Priority order, highest first: mem stall, MDU, branch flush, load-use.
REQ-019 Mem stall (mem_req=1 and dmem_ready=0, in any state):
- all five enables are 0; no flushes.
- from RUN, go to MEM_WAIT; in MDU_BUSY, stay in MDU_BUSY.
REQ-020 MEM_WAIT with dmem_ready=1 is evaluated exactly as RUN in the same cycle, including its outputs and next state.
REQ-021 MDU entry (RUN, ex_is_mdu=1, no mem stall):
- mdu_start=1; pc_en, if_id_en, id_ex_en, ex_mem_en are 0; ex_mem_flush=1; mem_wb_en=1.
- next state MDU_BUSY.
REQ-022 MDU_BUSY with mdu_done=0 and no mem stall: same outputs as REQ-021 but mdu_start=0.
REQ-023 MDU_BUSY with mdu_done=1 and no mem stall: all enables 1, no flushes, next state RUN.
REQ-024 mdu_start asserts only on the RUN-to-MDU_BUSY transition cycle, and never on two consecutive cycles.
REQ-025 Branch flush (RUN, ex_branch_taken=1, no higher-priority event):
- if_id_flush=1 and id_ex_flush=1; pc_en=1 so the PC loads the target.
- state stays RUN.
REQ-026 Load-use (RUN, ex_mem_read=1, ex_rd_addr!=0, and (id_uses_rs1 and id_rs1_addr==ex_rd_addr) or (id_uses_rs2 and id_rs2_addr==ex_rd_addr)):
- pc_en=0, if_id_en=0, id_ex_flush=1; the stall lasts one cycle.
- state stays RUN.
REQ-027 Branch flush and load-use in the same cycle: only the branch flush applies, and pc_en=1.
REQ-028 stall_cycles increments by 1 in each cycle with pc_en=0 and rst=0, and saturates at all-ones.
REQ-029 flush_count increments by 1 in each cycle a branch flush is applied, and saturates at all-ones.
REQ-030 ex_rd_addr=0 never causes a load-use stall.

Reset
REQ-031 While rst=1:
- all enables, flushes and mdu_start are 0.
- on the clock edge, state goes to RUN and both counters clear to 0.
REQ-032 Reset in MDU_BUSY or MEM_WAIT returns to RUN on the next edge with no mdu_start pulse; a held mdu_done afterwards is ignored until a new MDU entry.
REQ-033 In the first cycle after reset deasserts, the block evaluates as RUN.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle.
- pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle.
- stall_cycles becomes 1.
REQ-035 Branch plus load-use in the same cycle: ex_branch_taken=1 and a load-use match.
- if_id_flush=1, id_ex_flush=1, pc_en=1.
- flush_count becomes 1; stall_cycles is unchanged.
REQ-036 MDU launch: ex_is_mdu=1, mdu_done raised 3 cycles after mdu_start.
- mdu_start is high for 1 cycle and state=01 for 3 cycles, with ex_mem_flush=1 throughout.
- all enables are 1 in the done cycle, then state=00; stall_cycles=4.
REQ-037 Memory wait: mem_req=1, dmem_ready=0 for 2 cycles then 1.
- all enables are 0 for 2 cycles and state=10, then all enables are 1 and state=00.
REQ-038 Mem stall during MDU_BUSY: dmem_ready=0 while mdu_done=1.
- state stays 01 with all enables 0; the block moves to RUN only in the first cycle with dmem_ready=1.
REQ-039 Reset and counters:
- rst asserted in MDU_BUSY gives state=00 and counters 0 on the next edge.
- with CNT_W=4, 20 stalled cycles leave stall_cycles=15.
